// File: rtl/pe_input_feeder_pkg.sv
// Shared types for the PE input feeder: configuration/instruction words, FSM states, counters.
// Optional build macro used by the feeder: PE_FEEDER_ZEROPAD_EN.
package pe_input_feeder_pkg;

  localparam int FEED_DW = 16;
  localparam int FEED_AW = 10;
  localparam int MAXPCH  = 8;
  localparam int MAXROWW = 9;

  typedef struct packed {
    logic [7:0] Pch;
    logic [7:0] Tw;
    logic [3:0] U;
    logic [3:0] R;
  } Conf;

  typedef struct packed {
    logic dval;
    logic start;
    logic reset;
    logic stall;
  } Inst;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    STREAM,
    STALL,
    DONE
  } FeedState;

  typedef struct packed {
    logic [MAXPCH-1:0]  ch;
    logic [MAXROWW-1:0] pix;
  } FeedCnt;

  // Pixels per row tile, Tw*U+R-1, kept to MAXROWW bits.
  function automatic logic [MAXROWW-1:0] row_tile_len(input Conf c);
    logic [15:0] t;
    t = 16'(c.Tw) * 16'(c.U) + 16'(c.R) - 16'd1;
    return t[MAXROWW-1:0];
  endfunction

endpackage

// File: rtl/pe_input_feeder_if.sv
// PE Input rdy/ack channel: the feeder drives rdy/data, the PE datapath controller drives ack.
interface pe_input_feeder_if
  import pe_input_feeder_pkg::*;
#(
  parameter int DW = FEED_DW
);
  logic          Input_rdy;
  logic          Input_ack;
  logic [DW-1:0] o_Input_data;

  modport master (output Input_rdy, output o_Input_data, input Input_ack);
  modport slave  (input Input_rdy, input o_Input_data, output Input_ack);
endinterface

// File: rtl/pe_feeder_skid.sv
// Small synchronous FIFO absorbing the one-cycle GLB read latency; head word is shown combinationally.
module pe_feeder_skid #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg, count_next;
  logic          do_push, do_pop, full;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO may still accept a word in the same cycle it releases one.
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/pe_input_feeder.sv
// Streams one input row tile (Pch words per pixel, channel innermost) from the GLB to the PE.
// Define PE_FEEDER_ZEROPAD_EN to add i_pad: leading/trailing pixels emitted as zeros without reads.
module pe_input_feeder
  import pe_input_feeder_pkg::*;
#(
  parameter int DW         = FEED_DW,
  parameter int AW         = FEED_AW,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  Conf               i_PEconf,
  input  Inst               i_PEinst,
  input  logic [AW-1:0]     i_base_addr,
  output logic              o_rd_en,
  output logic [AW-1:0]     o_rd_addr,
  input  logic [DW-1:0]     i_rd_data,
`ifdef PE_FEEDER_ZEROPAD_EN
  input  logic [1:0]        i_pad,
`endif
  pe_input_feeder_if.master in_ch,
  output logic              o_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  FeedState           state_reg, state_next;
  FeedCnt             cnt_reg;
  logic [MAXPCH-1:0]  pch_reg;
  logic [MAXROWW-1:0] row_tile_reg;
  logic [1:0]         pad_reg;
  logic [AW-1:0]      addr_reg;
  logic               inflight_reg, inflight_pad_reg;

  logic [1:0]         pad_in;
  logic               flush, pop, push, issue, is_pad, all_issued, finish, empty_tile, last_ch;
  logic [CW:0]        slots_used;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic [DW-1:0]      fifo_head, push_data;

`ifdef PE_FEEDER_ZEROPAD_EN
  assign pad_in = i_pad;
`else
  assign pad_in = 2'd0;
`endif

  assign flush      = i_PEinst.dval && i_PEinst.reset;
  assign pop        = !fifo_empty && in_ch.Input_ack;
  assign all_issued = (cnt_reg.pix == row_tile_reg);
  assign last_ch    = (cnt_reg.ch == pch_reg - 1'b1);
  assign is_pad     = ({1'b0, cnt_reg.pix} < (MAXROWW+1)'(pad_reg)) ||
                      (({1'b0, cnt_reg.pix} + (MAXROWW+1)'(pad_reg)) >= {1'b0, row_tile_reg});
  assign empty_tile = (i_PEconf.Pch == '0) || (row_tile_len(i_PEconf) == '0);

  // Credit the slot being popped this cycle so a continuous ack sustains one word per cycle.
  assign slots_used = (CW+1)'(fifo_count) + (CW+1)'(inflight_reg) - (CW+1)'(pop);
  assign issue      = (state_reg == STREAM) && !flush && !all_issued &&
                      (slots_used < (CW+1)'(FIFO_DEPTH));

  assign o_rd_en    = issue && !is_pad;
  assign o_rd_addr  = addr_reg;
  assign push       = inflight_reg && !flush;
  assign push_data  = inflight_pad_reg ? '0 : i_rd_data;
  assign finish     = all_issued && !inflight_reg &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));
  assign o_done     = (state_reg == DONE);

  assign in_ch.Input_rdy    = !fifo_empty;
  assign in_ch.o_Input_data = fifo_empty ? '0 : fifo_head;

  always_comb begin
    state_next = state_reg;
    if (i_PEinst.dval) begin
      if (i_PEinst.reset) begin
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE:    if (i_PEinst.start) state_next = INIT;
          INIT:    state_next = empty_tile ? DONE : STREAM;
          STREAM: begin
            if (finish)               state_next = DONE;
            else if (i_PEinst.stall)  state_next = STALL;
          end
          STALL:   if (!i_PEinst.stall) state_next = STREAM;
          DONE:    state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg          <= '0;
      pch_reg          <= '0;
      row_tile_reg     <= '0;
      pad_reg          <= '0;
      addr_reg         <= '0;
      inflight_reg     <= 1'b0;
      inflight_pad_reg <= 1'b0;
    end else if (flush) begin
      cnt_reg          <= '0;
      inflight_reg     <= 1'b0;
      inflight_pad_reg <= 1'b0;
    end else begin
      inflight_reg     <= issue;
      inflight_pad_reg <= issue && is_pad;
      if (state_reg == INIT && i_PEinst.dval) begin
        pch_reg      <= i_PEconf.Pch;
        row_tile_reg <= row_tile_len(i_PEconf);
        pad_reg      <= pad_in;
        addr_reg     <= i_base_addr;
        cnt_reg      <= '0;
      end else if (issue) begin
        if (last_ch) begin
          cnt_reg.ch  <= '0;
          cnt_reg.pix <= cnt_reg.pix + 1'b1;
        end else begin
          cnt_reg.ch  <= cnt_reg.ch + 1'b1;
        end
        // GLB addresses are contiguous over unpadded words, so a running pointer replaces pix*Pch+ch.
        if (!is_pad) addr_reg <= addr_reg + 1'b1;
      end
    end
  end

  pe_feeder_skid #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_skid (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pe_input_feeder.sv
// Scoreboard bench for pe_input_feeder: expected words queued per tile, compared on each transfer.
module tb_pe_input_feeder;
  import pe_input_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  Conf         conf;
  Inst         inst;
  logic [9:0]  base;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic        done;
`ifdef PE_FEEDER_ZEROPAD_EN
  logic [1:0]  pad = 2'd0;
`endif

  pe_input_feeder_if #(.DW(16)) ch_if ();

  pe_input_feeder #(.DW(16), .AW(10), .FIFO_DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_PEconf    (conf),
    .i_PEinst    (inst),
    .i_base_addr (base),
    .o_rd_en     (rd_en),
    .o_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
`ifdef PE_FEEDER_ZEROPAD_EN
    .i_pad       (pad),
`endif
    .in_ch       (ch_if),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] glbval(input logic [9:0] a);
    return 16'hC000 | {6'd0, a};
  endfunction

  // GLB model: one-cycle registered read
  always @(posedge clk) if (rd_en) rd_data <= glbval(rd_addr);

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int ack_mode = 3;
  int rd_cnt = 0, done_cnt = 0, rdy_cnt = 0, stall_viol = 0;
  logic stall_d = 1'b0;
  logic held = 1'b0;
  logic [15:0] held_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    ch_if.Input_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0: ch_if.Input_ack = 1'b1;
        1: ch_if.Input_ack = ~ch_if.Input_ack;
        2: ch_if.Input_ack = 1'($urandom_range(0, 1));
        default: ch_if.Input_ack = 1'b0;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
      if (stall_d && rd_en) stall_viol++;
      stall_d = inst.stall;
      if (ch_if.Input_rdy) rdy_cnt++;
      if (done) begin
        done_cnt++;
        chk("rdy_at_done", {31'd0, ch_if.Input_rdy}, 32'd0);
      end
      if (held) begin
        chk("hold_rdy", {31'd0, ch_if.Input_rdy}, 32'd1);
        chk("hold_data", {16'd0, ch_if.o_Input_data}, {16'd0, held_data});
      end
      if (ch_if.Input_rdy && ch_if.Input_ack) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", {16'd0, ch_if.o_Input_data}, 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("word", {16'd0, ch_if.o_Input_data}, {16'd0, e});
          $display("xfer data=%h exp=%h", ch_if.o_Input_data, e);
        end
        held = 1'b0;
      end else if (ch_if.Input_rdy) begin
        held = 1'b1;
        held_data = ch_if.o_Input_data;
      end else begin
        held = 1'b0;
      end
      if (inst.reset) held = 1'b0;
    end
  end

  task automatic run_tile(input int pch, input int tw, input int u, input int r,
                          input logic [9:0] b, input int pd, input int mode,
                          input int stall_at, input string name);
    int rt, words, nreads, cyc;
    rt = (tw * u + r - 1) & 511;
    words = pch * rt;
    nreads = 0;
    for (int p = 0; p < rt; p++) begin
      for (int c = 0; c < pch; c++) begin
        if (p < pd || p >= rt - pd) begin
          exp_q.push_back(16'h0000);
        end else begin
          exp_q.push_back(glbval(10'((b + (p - pd) * pch + c) & 1023)));
          nreads++;
        end
      end
    end
    conf.Pch = 8'(pch);
    conf.Tw  = 8'(tw);
    conf.U   = 4'(u);
    conf.R   = 4'(r);
    base     = b;
`ifdef PE_FEEDER_ZEROPAD_EN
    pad      = 2'(pd);
`endif
    ack_mode = mode;
    rd_cnt = 0; done_cnt = 0; rdy_cnt = 0; stall_viol = 0;
    @(posedge clk); #1;
    inst.start = 1'b1;
    @(posedge clk); #1;
    inst.start = 1'b0;
    cyc = 1;
    while (done_cnt == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      if (cyc == stall_at)     inst.stall = 1'b1;
      if (cyc == stall_at + 5) inst.stall = 1'b0;
      cyc++;
    end
    inst.stall = 1'b0;
    chk({name, "_timeout"}, {31'd0, cyc < 3000}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_reads"}, 32'(rd_cnt), 32'(nreads));
    if (stall_at >= 0) chk({name, "_stall_rd"}, 32'(stall_viol), 32'd0);
    if (words == 0) chk({name, "_rdy"}, 32'(rdy_cnt), 32'd0);
    if (mode == 0 && stall_at < 0 && words > 0)
      chk({name, "_thru"}, {31'd0, cyc <= words + 8}, 32'd1);
    $display("tile %s words=%0d reads=%0d cycles=%0d", name, words, rd_cnt, cyc);
    exp_q.delete();
  endtask

  initial begin
    conf = '0;
    inst = '0;
    inst.dval = 1'b1;
    base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",  {31'd0, ch_if.Input_rdy}, 32'd0);
    chk("rst_rden", {31'd0, rd_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {16'd0, ch_if.o_Input_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_tile(2, 2, 1, 3, 10'h010, 0, 0, -1, "basic");
    run_tile(2, 2, 1, 3, 10'h010, 0, 1, -1, "toggle");
    run_tile(2, 2, 1, 3, 10'h020, 0, 0, 4, "stall");

    // Abort a tile with two words buffered
    conf.Pch = 8'd2; conf.Tw = 8'd2; conf.U = 4'd1; conf.R = 4'd3;
    base = 10'h040;
    ack_mode = 3;
    @(posedge clk); #1;
    inst.start = 1'b1;
    @(posedge clk); #1;
    inst.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_pre_rdy", {31'd0, ch_if.Input_rdy}, 32'd1);
    inst.reset = 1'b1;
    done_cnt = 0;
    @(posedge clk); #1;
    inst.reset = 1'b0;
    chk("abort_rdy", {31'd0, ch_if.Input_rdy}, 32'd0);
    rd_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle_rd", 32'(rd_cnt), 32'd0);
    chk("abort_idle_rdy", {31'd0, ch_if.Input_rdy}, 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    $display("abort tile done");
    run_tile(2, 2, 1, 3, 10'h050, 0, 0, -1, "after_abort");

    run_tile(0, 2, 1, 3, 10'h010, 0, 0, -1, "pch0");
    run_tile(2, 1, 1, 2, 10'h3FE, 0, 2, -1, "wrap");
    run_tile(3, 4, 2, 2, 10'h100, 0, 2, -1, "rand");
`ifdef PE_FEEDER_ZEROPAD_EN
    run_tile(2, 2, 1, 3, 10'h010, 1, 0, -1, "pad");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
